// File: rtl/gap_pkg.sv
// Shared definitions for the global average pool.
//   gap_state_t   : controller state encoding (accumulate, scale, output)
//   sat_to_width  : generic signed saturation of a 64-bit value to a narrower
//                   signed range; reused by other quantising stages.
package gap_pkg;

    typedef enum logic [1:0] {
        GAP_ACCUM  = 2'd0,
        GAP_SCALE  = 2'd1,
        GAP_OUTPUT = 2'd2
    } gap_state_t;

    // Clamp val into [-2^(width-1), 2^(width-1)-1]; result is still 64 bits wide.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] val,
                                                        input int                 width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/gap_scale.sv
// Single-channel scaler for the global average pool.
// Multiplies a channel sum by the fixed-point reciprocal of the pixel count,
// shifts the fraction away and saturates to DATA_WIDTH. One-cycle registered.
// Build option: define GAP_ROUND_EN to round half toward +inf before the
// shift; otherwise the shift floors.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i         acc_i/idx_i carry a channel to scale this cycle
//   acc_i           signed channel sum
//   idx_i           channel index travelling with the sum
//   valid_o         res_o/idx_o hold a freshly scaled channel
//   res_o           saturated signed average
//   idx_o           channel index of res_o
module gap_scale
    import gap_pkg::*;
#(
    parameter int ACC_WIDTH   = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int RECIP_SHIFT = 24,
    parameter int RECIP       = 342393,
    parameter int IDX_W       = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [IDX_W-1:0]      idx_i,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] res_o,
    output logic        [IDX_W-1:0]      idx_o
);

    // Reciprocal is non-negative, so one extra bit keeps it positive as signed.
    localparam int RECIP_W = RECIP_SHIFT + 2;
    localparam int PROD_W  = ACC_WIDTH + RECIP_W;
    localparam logic signed [RECIP_W-1:0] RECIP_S = RECIP_W'(RECIP);
    localparam logic signed [PROD_W-1:0]  HALF_S  = PROD_W'(64'sd1 <<< (RECIP_SHIFT - 1));

    logic signed [PROD_W-1:0]     prod_s;
    logic signed [PROD_W-1:0]     rnd_s;
    logic signed [PROD_W-1:0]     shift_s;
    logic signed [DATA_WIDTH-1:0] res_d;
    logic signed [DATA_WIDTH-1:0] res_q;
    logic        [IDX_W-1:0]      idx_q;
    logic                         valid_q;

    // Full-width product, optional half-LSB bias, arithmetic shift, saturate.
    always_comb begin
        prod_s = PROD_W'(acc_i) * PROD_W'(RECIP_S);
`ifdef GAP_ROUND_EN
        rnd_s  = prod_s + HALF_S;
`else
        rnd_s  = prod_s;
`endif
        shift_s = rnd_s >>> RECIP_SHIFT;
        res_d   = DATA_WIDTH'(sat_to_width(64'(shift_s), DATA_WIDTH));
    end

    // Result register with the index it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_i;
            res_q   <= res_d;
            idx_q   <= idx_i;
        end
    end

    assign valid_o = valid_q;
    assign res_o   = res_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/global_avg_pool.sv
// Streaming global average pool: accumulates a full IN_HEIGHT x IN_WIDTH
// frame (one pixel of CHANNELS values per beat), scales each channel sum by
// 1/(H*W) one channel per cycle through gap_scale, then offers the pooled
// vector on a valid/ready handshake.
// Build option: GAP_ROUND_EN (see gap_scale) selects round-half-up scaling.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   pixel beat handshake (ready only while accumulating)
//   in_last             producer's end-of-frame marker (checked, not trusted)
//   data_in             CHANNELS signed values, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready pooled vector handshake
//   data_out            pooled vector, same packing as data_in
//   frame_err           sticky: in_last disagreed with the pixel count
module global_avg_pool
    import gap_pkg::*;
#(
    parameter int CHANNELS    = 16,
    parameter int IN_HEIGHT   = 7,
    parameter int IN_WIDTH    = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int RECIP_SHIFT = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           frame_err
);

    localparam int NPIX      = IN_HEIGHT * IN_WIDTH;
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(NPIX) + 1;
    localparam int RECIP     = ((32'sd1 <<< RECIP_SHIFT) + NPIX - 1) / NPIX;
    localparam int CNT_W     = $clog2(NPIX + 1);
    localparam int IDX_W     = $clog2(CHANNELS + 1);

    gap_state_t                    state_q, state_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic signed [ACC_WIDTH-1:0]   acc_q [CHANNELS];
    logic signed [ACC_WIDTH-1:0]   acc_d [CHANNELS];
    logic [IDX_W-1:0]              sidx_q, sidx_d;
    logic                          out_valid_q, out_valid_d;
    logic [CHANNELS*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                          frame_err_q, frame_err_d;

    logic                          last_beat_s;
    logic signed [ACC_WIDTH-1:0]   sc_acc_s;
    logic                          sc_valid_in_s;
    logic                          sc_valid_s;
    logic signed [DATA_WIDTH-1:0]  sc_res_s;
    logic [IDX_W-1:0]              sc_idx_s;

    assign in_ready  = (state_q == GAP_ACCUM);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign frame_err = frame_err_q;

    // Pick the accumulator addressed by the scale index; index CHANNELS is the drain slot.
    always_comb begin
        sc_acc_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sc_acc_s = (sidx_q == IDX_W'(c)) ? acc_q[c] : sc_acc_s;
        end
        sc_valid_in_s = (state_q == GAP_SCALE) && (sidx_q < IDX_W'(CHANNELS));
    end

    gap_scale #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .RECIP_SHIFT (RECIP_SHIFT),
        .RECIP       (RECIP),
        .IDX_W       (IDX_W)
    ) u_scale (
        .clk     (clk),
        .rst     (rst),
        .valid_i (sc_valid_in_s),
        .acc_i   (sc_acc_s),
        .idx_i   (sidx_q),
        .valid_o (sc_valid_s),
        .res_o   (sc_res_s),
        .idx_o   (sc_idx_s)
    );

    // Next-state logic: frame accumulation, channel sequencing, output handshake.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        sidx_d      = sidx_q;
        out_valid_d = out_valid_q;
        frame_err_d = frame_err_q;
        last_beat_s = (count_q == CNT_W'(NPIX - 1));

        // Scaled channels land one cycle after issue; nothing else touches data_out.
        data_out_d = data_out_q;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out_d[c*DATA_WIDTH +: DATA_WIDTH] =
                (sc_valid_s && (sc_idx_s == IDX_W'(c))) ? sc_res_s
                                                        : data_out_q[c*DATA_WIDTH +: DATA_WIDTH];
        end

        case (state_q)
            GAP_ACCUM: begin
                if (in_valid) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_d[c] = acc_q[c] +
                            {{(ACC_WIDTH-DATA_WIDTH){data_in[c*DATA_WIDTH + DATA_WIDTH - 1]}},
                             data_in[c*DATA_WIDTH +: DATA_WIDTH]};
                    end
                    // The count decides frame end; in_last is only audited.
                    frame_err_d = frame_err_q | (in_last != last_beat_s);
                    if (last_beat_s) begin
                        state_d = GAP_SCALE;
                        count_d = '0;
                        sidx_d  = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    state_d = GAP_ACCUM;
                end
            end
            GAP_SCALE: begin
                // Index CHANNELS is one extra cycle letting the last result drain.
                if (sidx_q == IDX_W'(CHANNELS)) begin
                    state_d     = GAP_OUTPUT;
                    out_valid_d = 1'b1;
                    sidx_d      = '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_d[c] = '0;
                    end
                end else begin
                    sidx_d = sidx_q + IDX_W'(1);
                end
            end
            GAP_OUTPUT: begin
                if (out_ready) begin
                    state_d     = GAP_ACCUM;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = GAP_ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GAP_ACCUM;
            count_q     <= '0;
            sidx_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            frame_err_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sidx_q      <= sidx_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            frame_err_q <= frame_err_d;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

endmodule

// File: tb/tb_global_avg_pool.sv
// Testbench for global_avg_pool: a 2x2 instance and a 7x7 instance, both
// 16 channels x 8 bits, driven one at a time (sel) against an arithmetic
// reference model of the pooled average.
module tb_global_avg_pool;

    localparam int CH = 16;
    localparam int DW = 8;
    localparam int VW = CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;   // 0: 2x2 instance, 1: 7x7 instance
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [VW-1:0] data_in = '0;

    logic          ir2, ov2, fe2, ir7, ov7, fe7;
    logic [VW-1:0] do2, do7;
    logic          ir_m, ov_m, fe_m;
    logic [VW-1:0] do_m;

    int checks = 0;
    int failures = 0;
    logic [VW-1:0] pix [49];

    always #5 clk = ~clk;

    global_avg_pool #(.CHANNELS(CH), .IN_HEIGHT(2), .IN_WIDTH(2), .DATA_WIDTH(DW), .RECIP_SHIFT(24)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir2), .in_last(in_last),
        .data_in(data_in), .out_valid(ov2), .out_ready(out_ready && !sel), .data_out(do2), .frame_err(fe2));

    global_avg_pool #(.CHANNELS(CH), .IN_HEIGHT(7), .IN_WIDTH(7), .DATA_WIDTH(DW), .RECIP_SHIFT(24)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir7), .in_last(in_last),
        .data_in(data_in), .out_valid(ov7), .out_ready(out_ready && sel), .data_out(do7), .frame_err(fe7));

    assign ir_m = sel ? ir7 : ir2;
    assign ov_m = sel ? ov7 : ov2;
    assign fe_m = sel ? fe7 : fe2;
    assign do_m = sel ? do7 : do2;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        else        return -((-a + b - 1) / b);
    endfunction

    // Average of each channel over pix[0..np-1], scaled by ceil(2^24/np).
    function automatic logic [VW-1:0] model(input int np);
        logic [VW-1:0] r;
        longint sum, recip, p, q;
        logic [DW-1:0] b;
        r = '0;
        recip = ((longint'(1) << 24) + np - 1) / np;
        for (int c = 0; c < CH; c++) begin
            sum = 0;
            for (int i = 0; i < np; i++) begin
                b = pix[i][c*DW +: DW];
                sum += longint'($signed(b));
            end
            p = sum * recip;
`ifdef GAP_ROUND_EN
            p += longint'(1) << 23;
`endif
            q = floor_div(p, longint'(1) << 24);
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            r[c*DW +: DW] = q[DW-1:0];
        end
        return r;
    endfunction

    task automatic fill_random(input int np, input bit extreme);
        logic [DW-1:0] b;
        for (int i = 0; i < np; i++) begin
            for (int c = 0; c < CH; c++) begin
                b = DW'($urandom);
                if (extreme) begin
                    case ($urandom_range(0, 3))
                        0: b = 8'h7f;
                        1: b = 8'h80;
                        2: b = 8'h00;
                        default: b = DW'($urandom);
                    endcase
                end
                pix[i][c*DW +: DW] = b;
            end
        end
    endtask

    // Present beats 0..n-1; in_last asserted on beat last_at only.
    task automatic drive_beats(input int n, input int last_at);
        int tmo;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = pix[i];
            in_last  = (i == last_at);
            tmo = 0;
            while (!ir_m && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 100) chk("in_ready_timeout", VW'(tmo), VW'(0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int np, input int last_at, input string tag,
                             input bit exp_err, input int hold, input bit early);
        int n;
        int bad;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] d0;
        exp_v = model(np);
        out_ready = early;
        drive_beats(np, last_at);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ov_m && n < 100);
        chk({tag, "_latency"}, VW'(n), VW'(CH + 1));
        chk({tag, "_data"}, do_m, exp_v);
        chk({tag, "_frame_err"}, VW'(fe_m), VW'(exp_err));
        chk({tag, "_rdy_in_output"}, VW'(ir_m), VW'(0));
        if (hold > 0) begin
            bad = 0;
            d0 = do_m;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                data_in  = {4{$urandom}};
                if (ir_m || !ov_m || do_m !== d0) bad++;
            end
            in_valid = 1'b0;
            chk({tag, "_hold_stable"}, VW'(bad), VW'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_after_hs"}, VW'(ov_m), VW'(0));
        chk({tag, "_ir_after_hs"}, VW'(ir_m), VW'(1));
        chk({tag, "_data_held"}, do_m, exp_v);
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", VW'(ir_m), VW'(1));
            chk("rst_out_valid", VW'(ov_m), VW'(0));
            chk("rst_data_out", do_m, VW'(0));
            chk("rst_frame_err", VW'(fe_m), VW'(0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        int cnt;
        reset_dut(3);

        // Test 1: ch0 4,8,12,16 on 2x2 -> 10
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = '0;
            v[7:0] = DW'(4 * (i + 1));
            pix[i] = v;
        end
        run_frame(4, 3, "t1", 1'b0, 0, 1'b0);
        v = do_m;
        chk("t1_ch0_const", VW'(v[7:0]), VW'(8'd10));

        // Test 2: ch0 1..4, ch1 -1..-4
        for (int i = 0; i < 4; i++) begin
            v = '0;
            v[7:0]  = DW'(i + 1);
            v[15:8] = DW'(-(i + 1));
            pix[i] = v;
        end
        run_frame(4, 3, "t2", 1'b0, 0, 1'b0);
        v = do_m;
`ifdef GAP_ROUND_EN
        chk("t2_ch0_const", VW'(v[7:0]), VW'(8'd3));
        chk("t2_ch1_const", VW'(v[15:8]), VW'(8'hfe));
`else
        chk("t2_ch0_const", VW'(v[7:0]), VW'(8'd2));
        chk("t2_ch1_const", VW'(v[15:8]), VW'(8'hfd));
`endif

        // Test 4: stall in OUTPUT for 20 cycles with in_valid high, then a fresh frame
        fill_random(4, 1'b0);
        run_frame(4, 3, "t4_hold", 1'b0, 20, 1'b0);
        fill_random(4, 1'b0);
        run_frame(4, 3, "t4_next", 1'b0, 0, 1'b0);

        // Random frames on 2x2, some with early out_ready
        for (int f = 0; f < 6; f++) begin
            fill_random(4, f[0]);
            run_frame(4, 3, "rnd2", 1'b0, 0, f[1]);
        end

        // Test 6: in_last on beat 2 -> sticky frame_err, output still formed
        fill_random(4, 1'b0);
        run_frame(4, 1, "t6_bad", 1'b1, 0, 1'b0);
        fill_random(4, 1'b0);
        run_frame(4, 3, "t6_sticky", 1'b1, 0, 1'b0);

        // Test 3: saturation and ceil reciprocal on 7x7
        sel = 1'b1;
        for (int i = 0; i < 49; i++) pix[i] = {CH{8'h7f}};
        run_frame(49, 48, "t3_pos", 1'b0, 0, 1'b0);
        chk("t3_pos_const", do_m, {CH{8'h7f}});
        for (int i = 0; i < 49; i++) pix[i] = {CH{8'h80}};
        run_frame(49, 48, "t3_neg", 1'b0, 0, 1'b0);
        chk("t3_neg_const", do_m, {CH{8'h80}});

        // Random 7x7 frames
        for (int f = 0; f < 3; f++) begin
            fill_random(49, f[0]);
            run_frame(49, 48, "rnd7", 1'b0, 0, f[1]);
        end

        // Missing in_last on the last beat
        fill_random(49, 1'b0);
        run_frame(49, 49, "miss_last", 1'b1, 0, 1'b0);

        // Test 5: reset after 30 beats, then a frame of 5s
        fill_random(49, 1'b0);
        drive_beats(30, -1);
        reset_dut(2);
        sel = 1'b1;
        for (int i = 0; i < 49; i++) pix[i] = {CH{8'd5}};
        run_frame(49, 48, "t5", 1'b0, 0, 1'b0);
        chk("t5_const", do_m, {CH{8'd5}});
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ov_m) cnt++;
        end
        chk("t5_single_output", VW'(cnt), VW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
